// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a 4-word register window on the CPU bus,
// a small TX FIFO, and a frame FSM serialising bytes LSB first at a programmable bit period.
module mmio_uart_tx #(
  parameter int DATA_W     = 32,
  parameter int BASE_ADDR  = 'hF0,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              sel,
  output logic              tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] BASE_V = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] DIV_RST_V = DATA_W'(DIV_RESET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // A programmed period of 0 would never expire; clamp it to one cycle.
  function automatic logic [DATA_W-1:0] f_div_eff(input logic [DATA_W-1:0] d);
    return (d == '0) ? DATA_W'(1) : d;
  endfunction

  logic [1:0]        w_off;
  logic              w_wr;
  logic              w_push;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_busy;
  logic              w_bit_end;
  logic [7:0]        w_pop_data;

  state_t            r_state;
  logic              r_tx;
  logic              r_ovf;
  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_per;
  logic [DATA_W-1:0] r_cyc;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  assign sel        = (mem_addr[DATA_W-1:2] == BASE_V[DATA_W-1:2]);
  assign w_off      = mem_addr[1:0];
  assign w_wr       = mem_wr_en && sel;
  assign w_push     = w_wr && (w_off == 2'd0);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // Acceptance looks only at the pre-edge count, so a same-edge pop does not make room.
  assign w_push_ok  = w_push && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_cyc == r_per - DATA_W'(1));
  assign w_pop      = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_pop_data = r_mem[r_rptr];
  assign tx         = r_tx;

  always_comb begin
    mem_rd_data = '0;
    if (sel) begin
      case (w_off)
        2'd1:    mem_rd_data[3:0] = {r_ovf, w_busy, w_empty, w_full};
        2'd2:    mem_rd_data = r_div;
        default: mem_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DIV_RST_V;
    end else if (w_wr && (w_off == 2'd2)) begin
      r_div <= mem_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_push && !w_push_ok) begin
      r_ovf <= 1'b1;
    end else if (w_wr && (w_off == 2'd1) && mem_wr_data[3]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= mem_wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM: each state holds tx for r_per cycles, tracked by r_cyc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cyc   <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_sh    <= w_pop_data;
            r_per   <= f_div_eff(r_div);
            r_cyc   <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_sh[0];
            r_cyc   <= '0;
            r_bit   <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_sh[1];
              r_sh  <= {1'b0, r_sh[7:1]};
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_pop) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
              r_sh    <= w_pop_data;
              r_per   <= f_div_eff(r_div);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
